// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The master side drives the operands and out_ready; the slave side is the multiplier.
interface fp_mul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Result;
   logic         NaN;
   logic         flag_nv;
   logic         flag_of;
   logic         flag_uf;
   logic         flag_nx;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Result, NaN, flag_nv, flag_of, flag_uf, flag_nx
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Result, NaN, flag_nv, flag_of, flag_uf, flag_nx
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Fully pipelined floating-point multiplier, round-to-nearest-even, subnormals in/out as zero.
// Register levels: classify/exp-sum, mantissa product, normalise, round/pack (output).
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic          clk,
   input logic          reset,
   fp_mul_pipe_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

   // One global stall freezes every stage, so ordering and occupancy are trivially preserved.
   logic stall;
   logic adv;
   assign stall        = bus.out_valid && !bus.out_ready;
   assign adv          = !stall;
   assign bus.in_ready = adv;

   logic [W-1:0]     op      [2];
   logic [EXP_W-1:0] op_exp  [2];
   logic [MAN_W:0]   op_man  [2];
   logic [1:0]       op_sign;
   logic [1:0]       is_nan;
   logic [1:0]       is_inf;
   logic [1:0]       is_zero;

   assign op[0] = bus.A;
   assign op[1] = bus.B;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         logic [EXP_W-1:0] e;
         logic [MAN_W-1:0] f;
         assign e           = op[gi][W-2:MAN_W];
         assign f           = op[gi][MAN_W-1:0];
         assign op_sign[gi] = op[gi][W-1];
         assign op_exp[gi]  = e;
         assign op_man[gi]  = {1'b1, f};
         assign is_nan[gi]  = (&e) && (|f);
         assign is_inf[gi]  = (&e) && !(|f);
         assign is_zero[gi] = (e == '0);
      end
   endgenerate

   logic                 s1_sign_c;
   logic                 s1_nv_c;
   logic                 s1_special_c;
   logic [W-1:0]         s1_spec_res_c;
   logic signed [EW-1:0] s1_exp_c;

   always_comb begin
      s1_sign_c     = op_sign[0] ^ op_sign[1];
      s1_nv_c       = (|is_nan) || (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]);
      s1_special_c  = 1'b1;
      s1_spec_res_c = QNAN;
      s1_exp_c      = $signed({2'b00, op_exp[0]}) + $signed({2'b00, op_exp[1]}) - BIAS;
      if (s1_nv_c)
         s1_spec_res_c = QNAN;
      else if (|is_inf)
         s1_spec_res_c = {s1_sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (|is_zero)
         s1_spec_res_c = {s1_sign_c, {(W - 1){1'b0}}};
      else
         s1_special_c = 1'b0;
   end

   logic                 s1_valid, s1_sign, s1_special, s1_nv;
   logic [W-1:0]         s1_spec_res;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W:0]       s1_man_a, s1_man_b;

   logic                 s2_valid, s2_sign, s2_special, s2_nv;
   logic [W-1:0]         s2_spec_res;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]        s2_prod;

   logic                 s3_valid, s3_sign, s3_special, s3_nv;
   logic [W-1:0]         s3_spec_res;
   logic signed [EW-1:0] s3_exp;
   logic [MAN_W:0]       s3_mant;
   logic                 s3_guard, s3_sticky;

   // Normalise: a product in [2,4) shifts right by one, i.e. the window is taken one bit higher.
   logic [PW-1:0]        norm_c;
   logic signed [EW-1:0] norm_exp_c;
   assign norm_c     = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
   assign norm_exp_c = s2_exp + EW'(s2_prod[PW-1]);

   logic                 round_up_c;
   logic [MAN_W+1:0]     man_sum_c;
   logic signed [EW-1:0] fin_exp_c;
   logic [W-1:0]         res_c;
   logic                 nan_c, nv_c, of_c, uf_c, nx_c;

   always_comb begin
      round_up_c = s3_guard && (s3_sticky || s3_mant[0]);
      man_sum_c  = {1'b0, s3_mant} + (MAN_W + 2)'(round_up_c);
      // A rounding carry leaves the low fraction bits zero, so only the exponent needs bumping.
      fin_exp_c  = s3_exp + EW'(man_sum_c[MAN_W+1]);
      res_c      = {s3_sign, fin_exp_c[EXP_W-1:0], man_sum_c[MAN_W-1:0]};
      nan_c      = 1'b0;
      nv_c       = 1'b0;
      of_c       = 1'b0;
      uf_c       = 1'b0;
      nx_c       = s3_guard || s3_sticky;
      if (s3_special) begin
         res_c = s3_spec_res;
         nan_c = s3_nv;
         nv_c  = s3_nv;
         nx_c  = 1'b0;
      end else if (fin_exp_c >= EXP_MAX) begin
         res_c = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         of_c  = 1'b1;
         nx_c  = 1'b1;
      end else if (fin_exp_c[EW-1] || (fin_exp_c == '0)) begin
         res_c = {s3_sign, {(W - 1){1'b0}}};
         uf_c  = 1'b1;
         nx_c  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid    <= 1'b0; s1_sign <= 1'b0; s1_special <= 1'b0; s1_nv <= 1'b0;
         s1_spec_res <= '0;   s1_exp  <= '0;   s1_man_a   <= '0;   s1_man_b <= '0;
         s2_valid    <= 1'b0; s2_sign <= 1'b0; s2_special <= 1'b0; s2_nv <= 1'b0;
         s2_spec_res <= '0;   s2_exp  <= '0;   s2_prod    <= '0;
         s3_valid    <= 1'b0; s3_sign <= 1'b0; s3_special <= 1'b0; s3_nv <= 1'b0;
         s3_spec_res <= '0;   s3_exp  <= '0;   s3_mant    <= '0;
         s3_guard    <= 1'b0; s3_sticky <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.Result    <= '0;
         bus.NaN       <= 1'b0;
         bus.flag_nv   <= 1'b0;
         bus.flag_of   <= 1'b0;
         bus.flag_uf   <= 1'b0;
         bus.flag_nx   <= 1'b0;
      end else if (adv) begin
         s1_valid    <= bus.in_valid;
         s1_sign     <= s1_sign_c;
         s1_special  <= s1_special_c;
         s1_nv       <= s1_nv_c;
         s1_spec_res <= s1_spec_res_c;
         s1_exp      <= s1_exp_c;
         s1_man_a    <= op_man[0];
         s1_man_b    <= op_man[1];

         s2_valid    <= s1_valid;
         s2_sign     <= s1_sign;
         s2_special  <= s1_special;
         s2_nv       <= s1_nv;
         s2_spec_res <= s1_spec_res;
         s2_exp      <= s1_exp;
         s2_prod     <= PW'(s1_man_a) * PW'(s1_man_b);

         s3_valid    <= s2_valid;
         s3_sign     <= s2_sign;
         s3_special  <= s2_special;
         s3_nv       <= s2_nv;
         s3_spec_res <= s2_spec_res;
         s3_exp      <= norm_exp_c;
         s3_mant     <= norm_c[PW-1 -: MAN_W+1];
         s3_guard    <= norm_c[MAN_W];
         s3_sticky   <= |norm_c[MAN_W-1:0];

         bus.out_valid <= s3_valid;
         if (s3_valid) begin
            bus.Result  <= res_c;
            bus.NaN     <= nan_c;
            bus.flag_nv <= nv_c;
            bus.flag_of <= of_c;
            bus.flag_uf <= uf_c;
            bus.flag_nx <= nx_c;
         end
      end
   end
endmodule
